// File: rtl/creador_mensaje_param.sv
// Telemetry message builder: snapshots N_CH channels and converts them one at a time
// through a shared double-dabble engine into "<tag><sign><digits>" ASCII fields.
module creador_mensaje_param #(
    parameter int               N_CH        = 19,
    parameter int               WIDTH       = 16,
    parameter int               DIGITS      = 4,
    parameter logic [N_CH-1:0]  SIGNED_MASK = '0,
    parameter logic [7:0]       TAG_BASE    = 8'h41
) (
    input  logic                            Clock,
    input  logic                            Reset_n,
    input  logic                            startBCD,
    input  logic [N_CH*WIDTH-1:0]           data_in,
    output logic                            busy,
    output logic                            doneBCD,
    output logic [N_CH*8*(DIGITS+2)-1:0]    mensaje,
    output logic [N_CH-1:0]                 overflow,
    output logic [2:0]                      dbg_state_o
);

    // Decimal digits needed to hold 2^w-1, i.e. ceil(w*log10(2)).
    function automatic int bcd_digits(input int w);
        logic [127:0] m;
        int           d;
        m = (128'd1 << w) - 128'd1;
        d = 0;
        for (int i = 0; i < 40; i++) begin
            if (m != 128'd0) begin
                m = m / 128'd10;
                d = d + 1;
            end
        end
        return (d < 1) ? 1 : d;
    endfunction

    localparam int F       = 8 * (DIGITS + 2);
    localparam int MSG_W   = N_CH * F;
    localparam int BCD_DIG = bcd_digits(WIDTH);
    localparam int EXT_DIG = (DIGITS > BCD_DIG) ? DIGITS : BCD_DIG;
    localparam int BCD_W   = 4 * BCD_DIG;
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CNT_W   = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_CONV   = 3'd2,
        S_STORE  = 3'd3,
        S_COMMIT = 3'd4
    } state_t;

    state_t                  state_q,    state_d;
    logic [N_CH*WIDTH-1:0]   shadow_q,   shadow_d;
    logic [CH_W-1:0]         ch_q,       ch_d;
    logic [CNT_W-1:0]        cnt_q,      cnt_d;
    logic [WIDTH-1:0]        mag_q,      mag_d;
    logic [BCD_W-1:0]        bcd_q,      bcd_d;
    logic                    neg_q,      neg_d;
    logic [MSG_W-1:0]        work_q,     work_d;
    logic [N_CH-1:0]         ovf_work_q, ovf_work_d;
    logic [MSG_W-1:0]        mensaje_q,  mensaje_d;
    logic [N_CH-1:0]         overflow_q, overflow_d;
    logic                    busy_q,     busy_d;
    logic                    done_q,     done_d;

    logic [WIDTH-1:0]        cur_v;
    logic                    cur_neg;
    logic [BCD_W-1:0]        bcd_adj;
    logic [BCD_W+WIDTH-1:0]  dabble;
    logic [4*EXT_DIG-1:0]    bcd_ext;
    logic                    sat;
    logic [F-1:0]            field;

    assign cur_v   = shadow_q[int'(ch_q)*WIDTH +: WIDTH];
    assign cur_neg = SIGNED_MASK[ch_q] & cur_v[WIDTH-1];

    // One double-dabble step: correct digits >= 5, then shift {bcd, mag} left.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < BCD_DIG; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        dabble = {bcd_adj, mag_q} << 1;
    end

    // Field formatting; digits above DIGITS force saturation to all nines.
    always_comb begin
        bcd_ext = '0;
        bcd_ext[BCD_W-1:0] = bcd_q;
        sat = 1'b0;
        for (int i = DIGITS; i < EXT_DIG; i++) begin
            if (bcd_ext[4*i +: 4] != 4'd0) begin
                sat = 1'b1;
            end
        end
        field = '0;
        field[F-1 -: 8] = TAG_BASE + 8'(ch_q);
        field[F-9 -: 8] = neg_q ? 8'h2D : 8'h2B;
        for (int j = 0; j < DIGITS; j++) begin
            field[F-17-8*j -: 8] = sat ? 8'h39 : {4'h3, bcd_ext[4*(DIGITS-1-j) +: 4]};
        end
    end

    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        ch_d       = ch_q;
        cnt_d      = cnt_q;
        mag_d      = mag_q;
        bcd_d      = bcd_q;
        neg_d      = neg_q;
        work_d     = work_q;
        ovf_work_d = ovf_work_q;
        mensaje_d  = mensaje_q;
        overflow_d = overflow_q;
        busy_d     = busy_q;
        done_d     = done_q;
        case (state_q)
            S_IDLE: begin
                if (startBCD) begin
                    shadow_d = data_in;
                    ch_d     = '0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                mag_d   = cur_neg ? (~cur_v + WIDTH'(1)) : cur_v;
                neg_d   = cur_neg;
                bcd_d   = '0;
                cnt_d   = '0;
                state_d = S_CONV;
            end
            S_CONV: begin
                bcd_d = dabble[BCD_W+WIDTH-1 -: BCD_W];
                mag_d = dabble[WIDTH-1:0];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_STORE;
                end
            end
            S_STORE: begin
                for (int k = 0; k < N_CH; k++) begin
                    if (ch_q == CH_W'(k)) begin
                        work_d[(N_CH-1-k)*F +: F] = field;
                        ovf_work_d[k]             = sat;
                    end
                end
                if (ch_q == CH_W'(N_CH - 1)) begin
                    state_d = S_COMMIT;
                end else begin
                    ch_d    = ch_q + CH_W'(1);
                    state_d = S_LOAD;
                end
            end
            S_COMMIT: begin
                // The last field lands in work_q on the STORE edge, so publish one cycle later.
                mensaje_d  = work_q;
                overflow_d = ovf_work_q;
                busy_d     = 1'b0;
                done_d     = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= S_IDLE;
            shadow_q   <= '0;
            ch_q       <= '0;
            cnt_q      <= '0;
            mag_q      <= '0;
            bcd_q      <= '0;
            neg_q      <= 1'b0;
            work_q     <= '0;
            ovf_work_q <= '0;
            mensaje_q  <= '0;
            overflow_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            ch_q       <= ch_d;
            cnt_q      <= cnt_d;
            mag_q      <= mag_d;
            bcd_q      <= bcd_d;
            neg_q      <= neg_d;
            work_q     <= work_d;
            ovf_work_q <= ovf_work_d;
            mensaje_q  <= mensaje_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy        = busy_q;
    assign doneBCD     = done_q;
    assign mensaje     = mensaje_q;
    assign overflow    = overflow_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_creador_mensaje_param.sv
// Directed + randomized bench for creador_mensaje_param: a default 19x16 instance
// and a small 3x8 instance, each checked against a decimal-arithmetic reference model.
module tb_creador_mensaje_param;

    localparam int          N0 = 19, W0 = 16, D0 = 4, F0 = 48, MW0 = N0 * F0;
    localparam logic [18:0] MASK0 = 19'h42004;
    localparam int          N1 = 3, W1 = 8, D1 = 3, F1 = 40, MW1 = N1 * F1;
    localparam logic [2:0]  MASK1 = 3'b010;

    // ---------------- clock / reset ----------------
    logic Clock;
    logic Reset_n;
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic                start0, busy0, done0;
    logic [N0*W0-1:0]    data0;
    logic [MW0-1:0]      msg0;
    logic [N0-1:0]       ovf0;
    logic [2:0]          dbg0;

    logic                start1, busy1, done1;
    logic [N1*W1-1:0]    data1;
    logic [MW1-1:0]      msg1;
    logic [N1-1:0]       ovf1;
    logic [2:0]          dbg1;

    creador_mensaje_param #(.N_CH(N0), .WIDTH(W0), .DIGITS(D0), .SIGNED_MASK(MASK0)) dut0 (
        .Clock(Clock), .Reset_n(Reset_n), .startBCD(start0), .data_in(data0),
        .busy(busy0), .doneBCD(done0), .mensaje(msg0), .overflow(ovf0), .dbg_state_o(dbg0)
    );

    creador_mensaje_param #(.N_CH(N1), .WIDTH(W1), .DIGITS(D1), .SIGNED_MASK(MASK1)) dut1 (
        .Clock(Clock), .Reset_n(Reset_n), .startBCD(start1), .data_in(data1),
        .busy(busy1), .doneBCD(done1), .mensaje(msg1), .overflow(ovf1), .dbg_state_o(dbg1)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [MW0-1:0] exp_q[$];
    logic [N0-1:0]  exp_ovf_q[$];
    logic [MW1-1:0] exp_s_q[$];
    logic [N1-1:0]  exp_sovf_q[$];

    task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: each field is tag, sign, then the magnitude (clamped to 10^d-1) in decimal.
    function automatic logic [1023:0] model_msg(input int n, input int w, input int d,
                                                input logic [1023:0] data, input logic [31:0] mask,
                                                output logic [31:0] ovf);
        logic [1023:0] msg, tmp;
        logic [63:0]   v, mag, lim, p, fld, wmask;
        logic          neg;
        msg   = '0;
        ovf   = '0;
        lim   = 64'd1;
        for (int i = 0; i < d; i++) lim = lim * 64'd10;
        lim   = lim - 64'd1;
        wmask = (64'd1 << w) - 64'd1;
        for (int k = 0; k < n; k++) begin
            tmp = data >> (k * w);
            v   = tmp[63:0] & wmask;
            neg = mask[k] && (((v >> (w - 1)) & 64'd1) == 64'd1);
            mag = neg ? ((64'd1 << w) - v) : v;
            if (mag > lim) begin
                ovf[k] = 1'b1;
                mag    = lim;
            end
            fld = 64'h41 + 64'(k);
            fld = (fld << 8) | (neg ? 64'h2D : 64'h2B);
            p = 64'd1;
            for (int i = 0; i < d - 1; i++) p = p * 64'd10;
            for (int j = 0; j < d; j++) begin
                fld = (fld << 8) | (64'h30 + (mag / p) % 64'd10);
                p   = p / 64'd10;
            end
            msg = msg | (1024'(fld) << ((n - 1 - k) * 8 * (d + 2)));
        end
        return msg;
    endfunction

    task automatic expect0(input logic [N0*W0-1:0] d);
        logic [1023:0] m;
        logic [31:0]   o;
        m = model_msg(N0, W0, D0, 1024'(d), 32'(MASK0), o);
        exp_q.push_back(m[MW0-1:0]);
        exp_ovf_q.push_back(o[N0-1:0]);
    endtask

    task automatic expect1(input logic [N1*W1-1:0] d);
        logic [1023:0] m;
        logic [31:0]   o;
        m = model_msg(N1, W1, D1, 1024'(d), 32'(MASK1), o);
        exp_s_q.push_back(m[MW1-1:0]);
        exp_sovf_q.push_back(o[N1-1:0]);
    endtask

    task automatic score0(input string tag);
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 1024'(0), 1024'(1));
        end else begin
            check({tag, "_msg"}, 1024'(msg0), 1024'(exp_q.pop_front()));
            check({tag, "_ovf"}, 1024'(ovf0), 1024'(exp_ovf_q.pop_front()));
        end
    endtask

    task automatic score1(input string tag);
        if (exp_s_q.size() == 0) begin
            check({tag, "_queue"}, 1024'(0), 1024'(1));
        end else begin
            check({tag, "_msg"}, 1024'(msg1), 1024'(exp_s_q.pop_front()));
            check({tag, "_ovf"}, 1024'(ovf1), 1024'(exp_sovf_q.pop_front()));
        end
    endtask

    // ---------------- drivers ----------------
    task automatic rand_data0(output logic [N0*W0-1:0] d);
        for (int k = 0; k < N0; k++) begin
            case ($urandom_range(0, 5))
                0:       d[k*W0 +: W0] = 16'h8000;
                1:       d[k*W0 +: W0] = 16'(9999 + $urandom_range(0, 1));
                default: d[k*W0 +: W0] = 16'($urandom_range(0, 65535));
            endcase
        end
    endtask

    task automatic rand_data1(output logic [N1*W1-1:0] d);
        for (int k = 0; k < N1; k++) d[k*W1 +: W1] = 8'($urandom_range(0, 255));
    endtask

    // Start on a falling edge; latency counts rising edges after the accepting edge.
    task automatic run0(input logic [N0*W0-1:0] d, output int lat);
        @(negedge Clock);
        data0  = d;
        start0 = 1'b1;
        expect0(d);
        @(posedge Clock);
        #1 start0 = 1'b0;
        lat = -1;
        for (int c = 1; c <= 2000; c++) begin
            @(posedge Clock);
            #1;
            if (done0) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic run1(input logic [N1*W1-1:0] d, output int lat);
        @(negedge Clock);
        data1  = d;
        start1 = 1'b1;
        expect1(d);
        @(posedge Clock);
        #1 start1 = 1'b0;
        lat = -1;
        for (int c = 1; c <= 500; c++) begin
            @(posedge Clock);
            #1;
            if (done1) begin
                lat = c;
                break;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [N0*W0-1:0] d, a, b;
        logic [N1*W1-1:0] s;
        logic [MW0-1:0]   prev_msg;
        logic [N0-1:0]    prev_ovf;
        int               lat, lat2;
        logic             stable, saw, dl;

        Reset_n = 1'b0;
        start0  = 1'b0;
        start1  = 1'b0;
        data0   = '0;
        data1   = '0;
        #12;
        check("rst_busy", 1024'(busy0), 1024'(0));
        check("rst_done", 1024'(done0), 1024'(0));
        check("rst_msg", 1024'(msg0), 1024'(0));
        check("rst_ovf", 1024'(ovf0), 1024'(0));
        check("rst_small_msg", 1024'({busy1, done1, msg1, ovf1}), 1024'(0));
        @(negedge Clock);
        Reset_n = 1'b1;

        // Unsigned, signed small negative and saturated unsigned in one snapshot.
        rand_data0(d);
        d[0*W0 +: W0]  = 16'd1234;
        d[5*W0 +: W0]  = 16'd65535;
        d[13*W0 +: W0] = 16'hFFFB;
        run0(d, lat);
        check("lat_343", 1024'(lat), 1024'(343));
        check("field0_A+1234", 1024'(msg0[MW0-1 -: F0]), 1024'(48'h412B31323334));
        check("field5_F+9999_sat", 1024'({msg0[(N0-5)*F0-1 -: F0], ovf0[5]}), 1024'({48'h462B39393939, 1'b1}));
        check("field13_N-0005", 1024'(msg0[(N0-13)*F0-1 -: F0]), 1024'(48'h4E2D30303035));
        check("busy_after_done", 1024'(busy0), 1024'(0));
        score0("run_a");

        // 9999 is representable; 0x8000 signed saturates with a minus sign.
        rand_data0(d);
        d[0*W0 +: W0]  = 16'd0;
        d[5*W0 +: W0]  = 16'd9999;
        d[13*W0 +: W0] = 16'h8000;
        run0(d, lat);
        check("field5_F+9999_exact", 1024'({msg0[(N0-5)*F0-1 -: F0], ovf0[5]}), 1024'({48'h462B39393939, 1'b0}));
        check("field13_N-9999", 1024'({msg0[(N0-13)*F0-1 -: F0], ovf0[13]}), 1024'({48'h4E2D39393939, 1'b1}));
        check("field0_A+0000", 1024'(msg0[MW0-1 -: F0]), 1024'(48'h412B30303030));
        score0("run_b");

        rand_data0(d);
        d[5*W0 +: W0]  = 16'd0;
        d[13*W0 +: W0] = 16'd0;
        run0(d, lat);
        check("field5_F+0000", 1024'(msg0[(N0-5)*F0-1 -: F0]), 1024'(48'h462B30303030));
        check("field13_N+0000", 1024'(msg0[(N0-13)*F0-1 -: F0]), 1024'(48'h4E2B30303030));
        score0("run_c");

        // Reset in the middle of the first channel's conversion.
        rand_data0(d);
        @(negedge Clock);
        data0  = d;
        start0 = 1'b1;
        @(posedge Clock);
        #1 start0 = 1'b0;
        repeat (10) @(posedge Clock);
        #3 Reset_n = 1'b0;
        #1;
        check("midrst_outputs", 1024'({busy0, done0, msg0, ovf0}), 1024'(0));
        @(negedge Clock);
        Reset_n = 1'b1;
        saw = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(posedge Clock);
            #1;
            if (done0 || busy0 || msg0 !== '0 || ovf0 !== '0) saw = 1'b1;
        end
        check("midrst_no_update", 1024'(saw), 1024'(0));

        for (int r = 0; r < 2; r++) begin
            rand_data0(d);
            run0(d, lat);
            check("rand_lat", 1024'(lat), 1024'(343));
            score0("rand");
        end

        // Handshake: data change and extra starts while busy are ignored.
        prev_msg = msg0;
        prev_ovf = ovf0;
        rand_data0(a);
        rand_data0(b);
        @(negedge Clock);
        data0  = a;
        start0 = 1'b1;
        expect0(a);
        @(posedge Clock);
        #1 start0 = 1'b0;
        stable = 1'b1;
        lat = -1;
        for (int c = 1; c <= 2000; c++) begin
            @(posedge Clock);
            #1;
            if (done0) begin
                lat = c;
                break;
            end
            if (msg0 !== prev_msg || ovf0 !== prev_ovf) stable = 1'b0;
            if (c == 5) begin
                data0  = b;
                start0 = 1'b1;
            end
            if (c == 6)   start0 = 1'b0;
            if (c == 200) start0 = 1'b1;
            if (c == 201) start0 = 1'b0;
        end
        check("hs_lat", 1024'(lat), 1024'(343));
        check("hs_msg_held_while_busy", 1024'(stable), 1024'(1));
        score0("hs_first_snapshot");
        repeat (100) @(posedge Clock);
        #1;
        check("hs_no_second_run", 1024'({done0, busy0}), 1024'(2'b10));

        // Back-to-back with start held high; second snapshot taken on the re-accept edge.
        rand_data0(a);
        rand_data0(b);
        @(negedge Clock);
        data0  = a;
        start0 = 1'b1;
        expect0(a);
        @(posedge Clock);
        #1;
        lat = -1;
        for (int c = 1; c <= 2000; c++) begin
            @(posedge Clock);
            #1;
            if (done0) begin
                lat = c;
                break;
            end
        end
        check("b2b_lat1", 1024'(lat), 1024'(343));
        score0("b2b_run1");
        data0 = b;
        expect0(b);
        lat2 = -1;
        dl   = 1'b1;
        for (int c = 1; c <= 2000; c++) begin
            @(posedge Clock);
            #1;
            if (c == 1) dl = done0;
            if (done0) begin
                lat2 = c;
                break;
            end
        end
        start0 = 1'b0;
        check("b2b_done_one_cycle", 1024'(dl), 1024'(0));
        check("b2b_spacing", 1024'(lat2), 1024'(344));
        score0("b2b_run2");

        // Small instance: 3 channels, 8 bits, 3 digits; never saturates.
        s = '0;
        s[0*W1 +: W1] = 8'd255;
        s[1*W1 +: W1] = 8'h80;
        s[2*W1 +: W1] = 8'($urandom_range(0, 255));
        run1(s, lat);
        check("small_lat_31", 1024'(lat), 1024'(31));
        check("small_field0_A+255", 1024'(msg1[MW1-1 -: F1]), 1024'(40'h412B323535));
        check("small_field1_B-128", 1024'(msg1[MW1-F1-1 -: F1]), 1024'(40'h422D313238));
        score1("small_a");
        for (int r = 0; r < 3; r++) begin
            rand_data1(s);
            run1(s, lat);
            check("small_rand_lat", 1024'(lat), 1024'(31));
            score1("small_rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
